// File: rtl/objects_mux_collision.sv
// Final pixel selector and per-frame collision reporter for the bitmap drawing interface.
// Picks the visible object by fixed priority and pulses player/rope-ball overlaps once per frame.
module objects_mux_collision #(
  parameter int unsigned BALL_COUNT = 4,
  parameter logic [7:0]  BG_DEFAULT = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    playerDrawingRequest,
  input  logic [7:0]              playerRGB,
  input  logic                    ropeDrawingRequest,
  input  logic [7:0]              ropeRGB,
  input  logic [BALL_COUNT-1:0]   ballDrawingRequest,
  input  logic [8*BALL_COUNT-1:0] ballRGB,
  input  logic                    bgDrawingRequest,
  input  logic [7:0]              bgRGB,
  output logic [7:0]              RGBOut,
  output logic                    playerHit,
  output logic [BALL_COUNT-1:0]   ropeHitBall,
  output logic [7:0]              hitCount
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] REPORT  = 1'b1;

  logic [0:0]            r_state, w_state_next;
  logic [7:0]            r_rgb, w_rgb_next;
  logic                  r_player_flag, w_player_flag_next;
  logic [BALL_COUNT-1:0] r_rope_flag, w_rope_flag_next;
  logic                  r_player_hit, w_player_hit_next;
  logic [BALL_COUNT-1:0] r_rope_hit, w_rope_hit_next;
  logic [7:0]            r_hit_count, w_hit_count_next;
  logic                  w_p_ov;
  logic [BALL_COUNT-1:0] w_r_ov;

  assign w_p_ov = playerDrawingRequest & (|ballDrawingRequest);
  assign w_r_ov = {BALL_COUNT{ropeDrawingRequest}} & ballDrawingRequest;

  // Priority mux: later assignments override earlier ones, so player ends up on top.
  always_comb begin
    w_rgb_next = bgDrawingRequest ? bgRGB : BG_DEFAULT;
    for (int i = int'(BALL_COUNT) - 1; i >= 0; i--) begin
      if (ballDrawingRequest[i]) w_rgb_next = ballRGB[8*i +: 8];
    end
    if (ropeDrawingRequest)   w_rgb_next = ropeRGB;
    if (playerDrawingRequest) w_rgb_next = playerRGB;
  end

  // Report FSM; on a frame boundary the flags reload with this pixel's overlap so it counts for the new frame.
  always_comb begin
    w_state_next       = r_state;
    w_player_flag_next = r_player_flag | w_p_ov;
    w_rope_flag_next   = r_rope_flag | w_r_ov;
    w_player_hit_next  = r_player_hit;
    w_rope_hit_next    = r_rope_hit;
    w_hit_count_next   = r_hit_count;
    case (r_state)
      COLLECT, REPORT: begin
        if (startOfFrame) begin
          w_player_hit_next  = r_player_flag;
          w_rope_hit_next    = r_rope_flag;
          w_player_flag_next = w_p_ov;
          w_rope_flag_next   = w_r_ov;
          if (r_player_flag && (r_hit_count != 8'hFF)) w_hit_count_next = r_hit_count + 8'd1;
          w_state_next = REPORT;
        end else if (r_state == REPORT) begin
          w_player_hit_next = 1'b0;
          w_rope_hit_next   = '0;
          w_state_next      = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= COLLECT;
      r_rgb         <= 8'h00;
      r_player_flag <= 1'b0;
      r_rope_flag   <= '0;
      r_player_hit  <= 1'b0;
      r_rope_hit    <= '0;
      r_hit_count   <= 8'h00;
    end else begin
      r_state       <= w_state_next;
      r_rgb         <= w_rgb_next;
      r_player_flag <= w_player_flag_next;
      r_rope_flag   <= w_rope_flag_next;
      r_player_hit  <= w_player_hit_next;
      r_rope_hit    <= w_rope_hit_next;
      r_hit_count   <= w_hit_count_next;
    end
  end

  assign RGBOut      = r_rgb;
  assign playerHit   = r_player_hit;
  assign ropeHitBall = r_rope_hit;
  assign hitCount    = r_hit_count;

endmodule

// File: tb/tb_objects_mux_collision.sv
// Scoreboard bench: each driven cycle queues its hand-computed expected outputs,
// and a monitor compares them just after the following clock edge.
module tb_objects_mux_collision;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof;
  logic        p_req, r_req, bg_req;
  logic [7:0]  p_rgb, r_rgb, bg_rgb;
  logic [3:0]  b_req;
  logic [31:0] b_rgb;
  logic [7:0]  rgb_out;
  logic        p_hit;
  logic [3:0]  r_hit;
  logic [7:0]  h_cnt;

  typedef struct {
    int         idx;
    logic [7:0] rgb;
    logic       ph;
    logic [3:0] rh;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_step   = 0;

  always #5 clk = ~clk;

  objects_mux_collision #(.BALL_COUNT(4), .BG_DEFAULT(8'h00)) dut (
    .clk                  (clk),
    .resetN               (rst_n),
    .startOfFrame         (sof),
    .playerDrawingRequest (p_req),
    .playerRGB            (p_rgb),
    .ropeDrawingRequest   (r_req),
    .ropeRGB              (r_rgb),
    .ballDrawingRequest   (b_req),
    .ballRGB              (b_rgb),
    .bgDrawingRequest     (bg_req),
    .bgRGB                (bg_rgb),
    .RGBOut               (rgb_out),
    .playerHit            (p_hit),
    .ropeHitBall          (r_hit),
    .hitCount             (h_cnt)
  );

  // Monitor: outputs just after edge n reflect the inputs driven for cycle n.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks += 4;
      if (rgb_out === e.rgb) n_pass++;
      else $display("FAIL rgb step %0d got %h want %h", e.idx, rgb_out, e.rgb);
      if (p_hit === e.ph) n_pass++;
      else $display("FAIL playerHit step %0d got %b want %b", e.idx, p_hit, e.ph);
      if (r_hit === e.rh) n_pass++;
      else $display("FAIL ropeHitBall step %0d got %b want %b", e.idx, r_hit, e.rh);
      if (h_cnt === e.cnt) n_pass++;
      else $display("FAIL hitCount step %0d got %h want %h", e.idx, h_cnt, e.cnt);
    end
  end

  task automatic idle();
    sof = 1'b0; p_req = 1'b0; r_req = 1'b0; b_req = 4'b0000; bg_req = 1'b0;
  endtask

  task automatic step(input logic [7:0] rgb, input logic ph, input logic [3:0] rh, input logic [7:0] cnt);
    exp_t e;
    e.idx = n_step; e.rgb = rgb; e.ph = ph; e.rh = rh; e.cnt = cnt;
    q.push_back(e);
    n_step++;
    @(negedge clk);
  endtask

  task automatic overlap_pb3();
    idle(); p_req = 1'b1; b_req = 4'b1000;
  endtask

  initial begin
    logic [7:0] c;
    p_rgb = 8'h1C; r_rgb = 8'hE0; bg_rgb = 8'h55;
    b_rgb = {8'h33, 8'h22, 8'h11, 8'h03};
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step(8'h00, 1'b0, 4'h0, 8'h00);
    rst_n = 1'b1;

    // Priority mux
    p_req = 1'b1; r_req = 1'b1; b_req = 4'b0001; bg_req = 1'b1;
    step(8'h1C, 1'b0, 4'h0, 8'h00);
    p_req = 1'b0; step(8'hE0, 1'b0, 4'h0, 8'h00);
    r_req = 1'b0; step(8'h03, 1'b0, 4'h0, 8'h00);
    b_req = 4'b0000; step(8'h55, 1'b0, 4'h0, 8'h00);
    bg_req = 1'b0; step(8'h00, 1'b0, 4'h0, 8'h00);
    b_req = 4'b0110; step(8'h11, 1'b0, 4'h0, 8'h00);
    b_req = 4'b1111; bg_req = 1'b1; step(8'h03, 1'b0, 4'h0, 8'h00);

    // Overlaps above set flags; reset discards them
    idle(); rst_n = 1'b0;
    step(8'h00, 1'b0, 4'h0, 8'h00);
    step(8'h00, 1'b0, 4'h0, 8'h00);
    rst_n = 1'b1;
    sof = 1'b1; step(8'h00, 1'b0, 4'h0, 8'h00);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h00);

    // Player/ball3 overlap for 5 pixels
    step(8'h00, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      overlap_pb3(); step(8'h1C, 1'b0, 4'h0, 8'h00);
    end
    idle(); step(8'h00, 1'b0, 4'h0, 8'h00);
    sof = 1'b1; step(8'h00, 1'b1, 4'h0, 8'h01);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h01);
    step(8'h00, 1'b0, 4'h0, 8'h01);
    sof = 1'b1; step(8'h00, 1'b0, 4'h0, 8'h01);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h01);

    // Rope over ball0 and ball2
    for (int i = 0; i < 3; i++) begin
      idle(); r_req = 1'b1; b_req = 4'b0101; step(8'hE0, 1'b0, 4'h0, 8'h01);
    end
    idle(); step(8'h00, 1'b0, 4'h0, 8'h01);
    sof = 1'b1; step(8'h00, 1'b0, 4'b0101, 8'h01);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h01);

    // Overlap only on the boundary pixel belongs to the new frame
    overlap_pb3(); sof = 1'b1; step(8'h1C, 1'b0, 4'h0, 8'h01);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h01);
    step(8'h00, 1'b0, 4'h0, 8'h01);
    sof = 1'b1; step(8'h00, 1'b1, 4'h0, 8'h02);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h02);

    // Back-to-back frame starts
    r_req = 1'b1; b_req = 4'b0010; step(8'hE0, 1'b0, 4'h0, 8'h02);
    idle(); p_req = 1'b1; b_req = 4'b0001; sof = 1'b1; step(8'h1C, 1'b0, 4'b0010, 8'h02);
    idle(); sof = 1'b1; step(8'h00, 1'b1, 4'h0, 8'h03);
    idle(); step(8'h00, 1'b0, 4'h0, 8'h03);

    // Saturation over 260 consecutive hit frames
    c = 8'h03;
    for (int i = 0; i < 260; i++) begin
      overlap_pb3(); step(8'h1C, 1'b0, 4'h0, c);
      if (c != 8'hFF) c = c + 8'd1;
      idle(); sof = 1'b1; step(8'h00, 1'b1, 4'h0, c);
    end
    idle(); step(8'h00, 1'b0, 4'h0, 8'hFF);
    sof = 1'b1; step(8'h00, 1'b0, 4'h0, 8'hFF);
    idle(); step(8'h00, 1'b0, 4'h0, 8'hFF);

    // Drain scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain left %0d want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/objects_mux_collision.md
Name: objects_mux_collision

Overview:
- Consumer end of the bitmap drawing interface. Every object bitmap (player, rope, balls) drives a drawingRequest/RGBout pair into this block.
- Per pixel, the block selects the visible object by fixed priority and registers the final 8-bit RGB toward the VGA controller.
- It also accumulates pixel-level overlaps over one frame and reports player-ball and rope-ball collisions to game control as per-frame pulses.

Parameters:
- BALL_COUNT, 4, number of ball bitmap inputs (1..8).
- BG_DEFAULT, 8'h00, background color used when bgDrawingRequest is low.

Ports:
- clk  input  1  pixel clock
- resetN  input  1  asynchronous active-low reset
- startOfFrame  input  1  one-cycle pulse at the first pixel of each frame
- playerDrawingRequest  input  1  player bitmap pixel is opaque
- playerRGB  input  8  player pixel color
- ropeDrawingRequest  input  1  rope pixel is opaque
- ropeRGB  input  8  rope pixel color
- ballDrawingRequest  input  BALL_COUNT  per-ball opaque flag
- ballRGB  input  8*BALL_COUNT  per-ball color; ball i occupies bits [8i+7:8i]
- bgDrawingRequest  input  1  background bitmap pixel valid
- bgRGB  input  8  background color
- RGBOut  output  8  registered final pixel color
- playerHit  output  1  one-cycle pulse: player touched any ball in the previous frame
- ropeHitBall  output  BALL_COUNT  one-cycle pulse vector: rope touched ball i in the previous frame
- hitCount  output  8  saturating count of frames in which playerHit fired

Behaviour:
- Reset (async, resetN low): RGBOut=8'h00, playerHit=0, ropeHitBall=0, hitCount=0, all internal frame flags=0.
- Pixel mux, latency 1 clk: RGBOut at cycle n+1 reflects the inputs sampled at cycle n. Priority, highest first:
  - player
  - rope
  - ball 0 .. ball BALL_COUNT-1 (lowest index wins)
  - bgRGB if bgDrawingRequest
  - BG_DEFAULT otherwise
- No transparency decoding here. Requests are trusted as-is: an 8'hFF color with its request high is drawn.
- Overlap detection, combinational on the current inputs:
  - pOv = playerDrawingRequest & |ballDrawingRequest
  - rOv[i] = ropeDrawingRequest & ballDrawingRequest[i]
- Frame flags (sticky within a frame): playerFlag |= pOv, ropeFlag[i] |= rOv[i], updated every clk.
- Report phase, state machine with states COLLECT and REPORT:
  - COLLECT: on startOfFrame, register playerHit<=playerFlag and ropeHitBall<=ropeFlag, then go to REPORT.
  - On that same cycle the flags reload with the current cycle's pOv/rOv (not cleared to 0), so an overlap on the startOfFrame pixel belongs to the new frame.
  - REPORT: lasts exactly 1 clk. Clear playerHit and ropeHitBall to 0 and return to COLLECT.
  - If startOfFrame arrives while in REPORT (back-to-back frames), treat it as a new COLLECT→REPORT transition: pulses are re-registered from the flags accumulated in the one intervening cycle.
- hitCount: increments when playerHit is registered as 1; saturates at 8'hFF and never wraps.
- Pulses never fire before the first startOfFrame after reset.
- Reset asserted mid-frame discards all accumulated flags; no pulse is emitted for the interrupted frame.
- Multiple balls overlapping the rope in one frame set multiple ropeHitBall bits in the same pulse.

Test Plan:
- Reset, then player=1/8'h1C, rope=1/8'hE0, ball0=1/8'h03, bg=1/8'h55 → RGBOut=8'h1C one clk later. Drop player → 8'hE0; drop rope → 8'h03; drop ball0 → 8'h55; drop bg → 8'h00.
- ball1 and ball2 both requesting with colors 8'h11/8'h22 → RGBOut=8'h22? No: RGBOut=8'h11, lowest index wins.
- Player and ball3 overlap for 5 pixels mid-frame, then startOfFrame → playerHit=1 for exactly 1 clk, one clk after startOfFrame; hitCount 0→1; a following frame with no overlap gives playerHit=0 at its start.
- Rope overlaps ball0 and ball2 in one frame → at next startOfFrame, ropeHitBall=4'b0101 for 1 clk, playerHit=0.
- Overlap only on the startOfFrame cycle itself → no pulse at that boundary; pulse at the following startOfFrame.
- Overlap mid-frame, then resetN low for 2 clks, then startOfFrame → no pulse, hitCount=0. Also: 260 consecutive hit frames → hitCount holds at 8'hFF.
